aes_keyex_multi: RTL and testbench

Iterative AES key-expansion engine supporting AES-128/192/256, selected per request by a runtime mode input. Generates one 32-bit schedule word per step into a 60-word round-key store that feeds the cipher datapath. S-box lookups go through an external shared S-box port whose latency is a build parameter.

---
 rtl/aes_keyex_pkg.sv | 50 +++++
 rtl/aes_keyex_word.sv | 26 ++
 rtl/aes_keyex_multi.sv | 189 ++++++++++++++++++
 tb/tb_aes_keyex_multi.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_keyex_pkg.sv
// Shared constants and helpers for the multi-size AES key-expansion engine:
// mode encoding, per-mode schedule sizes, xtime and RotWord.
package aes_keyex_pkg;

  localparam logic [1:0] MODE_128 = 2'd0;
  localparam logic [1:0] MODE_192 = 2'd1;
  localparam logic [1:0] MODE_256 = 2'd2;
  localparam logic [1:0] MODE_BAD = 2'd3;

  localparam int MAX_WORDS = 60;

  typedef enum logic [1:0] {
    WT_PLAIN  = 2'd0,
    WT_ROTSUB = 2'd1,
    WT_SUB    = 2'd2
  } word_type_e;

  function automatic logic [3:0] nk_of(input logic [1:0] mode);
    case (mode)
      MODE_192: nk_of = 4'd6;
      MODE_256: nk_of = 4'd8;
      default:  nk_of = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      MODE_192: nr_of = 4'd12;
      MODE_256: nr_of = 4'd14;
      default:  nr_of = 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] nwords_of(input logic [1:0] mode);
    case (mode)
      MODE_192: nwords_of = 6'd52;
      MODE_256: nwords_of = 6'd60;
      default:  nwords_of = 6'd44;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_keyex_word.sv
// Combinational next-word step of the AES key schedule: w[i] from w[i-Nk],
// w[i-1], the SubWord result and rcon, selected by word type.
module aes_keyex_word
  import aes_keyex_pkg::*;
(
  input  logic [31:0] w_nk,
  input  logic [31:0] w_prev,
  input  logic [31:0] sbox,
  input  logic [7:0]  rcon,
  input  word_type_e  wtype,
  output logic [31:0] w_new
);

  logic [31:0] temp;

  always_comb begin
    temp = w_prev;
    case (wtype)
      WT_ROTSUB: temp = sbox ^ {rcon, 24'h0};
      WT_SUB:    temp = sbox;
      default:   temp = w_prev;
    endcase
    w_new = w_nk ^ temp;
  end

endmodule

// File: rtl/aes_keyex_multi.sv
// Iterative AES-128/192/256 key expansion into a 60-word round-key store.
// Optional build macro AES_KEYEX_ZEROIZE_EN adds the i_zeroize clear input.
module aes_keyex_multi
  import aes_keyex_pkg::*;
#(
  parameter int SBOX_LAT = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
`ifdef AES_KEYEX_ZEROIZE_EN
  input  logic          i_zeroize,
`endif
  input  logic [255:0]  i_key,
  input  logic [1:0]    i_mode,
  input  logic          i_key_en,
  output logic          o_busy,
  output logic          o_key_ok,
  output logic          o_err,
  output logic [3:0]    o_nr,
  output logic [1919:0] o_exkey,
  output logic          o_sbox_use,
  output logic [31:0]   o_sbox_din,
  input  logic [31:0]   i_sbox_dout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GEN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam bit SBOX_REG = (SBOX_LAT == 1);

  logic [1:0]  state;
  logic [1:0]  mode_q;
  logic [5:0]  idx;
  logic [2:0]  col;
  logic [7:0]  rcon;
  logic        key_ok;
  logic        err;
  logic [3:0]  nr;
  logic [31:0] win [8];
  logic [31:0] store [MAX_WORDS];
  logic [31:0] key_words [8];

  logic        zeroize;
  logic        start_ok;
  logic        start_bad;
  logic        gen_active;
  logic        commit;
  logic        last;
  logic [3:0]  nk;
  logic [31:0] w_nk;
  logic [31:0] w_prev;
  logic [31:0] w_new;
  word_type_e  wtype;

`ifdef AES_KEYEX_ZEROIZE_EN
  assign zeroize = i_zeroize;
`else
  assign zeroize = 1'b0;
`endif

  for (genvar k = 0; k < 8; k++) begin : g_key_words
    assign key_words[k] = i_key[255-32*k -: 32];
  end

  assign start_ok   = i_key_en && (i_mode != MODE_BAD);
  assign start_bad  = i_key_en && (i_mode == MODE_BAD);
  assign gen_active = (state == ST_GEN) || (state == ST_WAIT);
  assign nk         = nk_of(mode_q);
  assign last       = (idx == nwords_of(mode_q) - 6'd1);

  // The window is right-aligned: win[7] is w[i-1], win[8-Nk] is w[i-Nk].
  assign w_prev = win[7];

  always_comb begin
    case (mode_q)
      MODE_192: w_nk = win[2];
      MODE_256: w_nk = win[0];
      default:  w_nk = win[4];
    endcase
  end

  always_comb begin
    wtype = WT_PLAIN;
    if (col == 3'd0)
      wtype = WT_ROTSUB;
    else if ((mode_q == MODE_256) && (col == 3'd4))
      wtype = WT_SUB;
  end

  // With a registered S-box an S-box word is issued in GEN and retired in WAIT.
  assign commit = ((state == ST_GEN) && (!SBOX_REG || (wtype == WT_PLAIN))) ||
                  (state == ST_WAIT);

  always_comb begin
    o_sbox_use = gen_active && (wtype != WT_PLAIN);
    o_sbox_din = '0;
    if (o_sbox_use)
      o_sbox_din = (wtype == WT_ROTSUB) ? rot_word(w_prev) : w_prev;
  end

  aes_keyex_word u_word (
    .w_nk   (w_nk),
    .w_prev (w_prev),
    .sbox   (i_sbox_dout),
    .rcon   (rcon),
    .wtype  (wtype),
    .w_new  (w_new)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst || zeroize) begin
      state  <= ST_IDLE;
      key_ok <= 1'b0;
      err    <= 1'b0;
      nr     <= 4'd0;
      mode_q <= MODE_128;
      idx    <= 6'd0;
      col    <= 3'd0;
    end else if (start_bad) begin
      state  <= ST_IDLE;
      key_ok <= 1'b0;
      err    <= 1'b1;
      nr     <= 4'd0;
    end else if (start_ok) begin
      state  <= ST_GEN;
      key_ok <= 1'b0;
      err    <= 1'b0;
      nr     <= 4'd0;
      mode_q <= i_mode;
      idx    <= {2'b00, nk_of(i_mode)};
      col    <= 3'd0;
    end else if (commit) begin
      idx <= idx + 6'd1;
      col <= ({1'b0, col} == nk - 4'd1) ? 3'd0 : col + 3'd1;
      if (last) begin
        state  <= ST_DONE;
        key_ok <= 1'b1;
        nr     <= nr_of(mode_q);
      end else begin
        state  <= ST_GEN;
      end
    end else if (state == ST_GEN) begin
      state <= ST_WAIT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (zeroize) begin
      rcon <= 8'h00;
      for (int j = 0; j < 8; j++) win[j] <= '0;
    end else if (start_ok) begin
      rcon <= 8'h01;
      case (i_mode)
        MODE_192: for (int j = 0; j < 6; j++) win[j+2] <= key_words[j];
        MODE_256: for (int j = 0; j < 8; j++) win[j]   <= key_words[j];
        default:  for (int j = 0; j < 4; j++) win[j+4] <= key_words[j];
      endcase
    end else if (commit) begin
      for (int j = 0; j < 7; j++) win[j] <= win[j+1];
      win[7] <= w_new;
      if (wtype == WT_ROTSUB)
        rcon <= xtime(rcon);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || zeroize || i_key_en) begin
      for (int k = 0; k < MAX_WORDS; k++) store[k] <= '0;
      if (!i_rst && !zeroize && start_ok)
        for (int k = 0; k < 8; k++)
          if (4'(k) < nk_of(i_mode))
            store[k] <= key_words[k];
    end else if (commit) begin
      store[idx] <= w_new;
    end
  end

  for (genvar k = 0; k < MAX_WORDS; k++) begin : g_exkey
    assign o_exkey[1919-32*k -: 32] = store[k];
  end

  assign o_busy   = gen_active;
  assign o_key_ok = key_ok;
  assign o_err    = err;
  assign o_nr     = nr;

endmodule

// File: tb/tb_aes_keyex_multi.sv
// Directed bench for aes_keyex_multi: one instance per S-box latency, shared
// stimulus, FIPS-197 key vectors. AES_KEYEX_ZEROIZE_EN enables the zeroize case.
module tb_aes_keyex_multi;

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [255:0]  key = '0;
  logic [1:0]    mode = '0;
  logic          key_en = 1'b0;
`ifdef AES_KEYEX_ZEROIZE_EN
  logic          zeroize = 1'b0;
`endif

  logic          busy0, ok0, err0, use0, busy1, ok1, err1, use1;
  logic [3:0]    nr0, nr1;
  logic [1919:0] exkey0, exkey1;
  logic [31:0]   din0, dout0, din1, dout1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ok0_cyc, ok1_cyc, sbox1_n;
  logic busy0_at_ok;

  always #5 clk = ~clk;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [2047:0] t;
    logic [31:0] r;
    t = SBOX_TAB;
    for (int b = 0; b < 4; b++) begin
      r[31-8*b -: 8] = t[2047-8*int'(w[31-8*b -: 8]) -: 8];
    end
    return r;
  endfunction

  assign dout0 = sub_word(din0);
  always @(posedge clk) dout1 <= sub_word(din1);

  aes_keyex_multi #(.SBOX_LAT(0)) dut0 (
    .i_clk(clk), .i_rst(rst),
`ifdef AES_KEYEX_ZEROIZE_EN
    .i_zeroize(zeroize),
`endif
    .i_key(key), .i_mode(mode), .i_key_en(key_en),
    .o_busy(busy0), .o_key_ok(ok0), .o_err(err0), .o_nr(nr0), .o_exkey(exkey0),
    .o_sbox_use(use0), .o_sbox_din(din0), .i_sbox_dout(dout0)
  );

  aes_keyex_multi #(.SBOX_LAT(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
`ifdef AES_KEYEX_ZEROIZE_EN
    .i_zeroize(zeroize),
`endif
    .i_key(key), .i_mode(mode), .i_key_en(key_en),
    .o_busy(busy1), .o_key_ok(ok1), .o_err(err1), .o_nr(nr1), .o_exkey(exkey1),
    .o_sbox_use(use1), .o_sbox_din(din1), .i_sbox_dout(dout1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wd(input logic [1919:0] ex, input int k);
    return ex[1919-32*k -: 32];
  endfunction

  function automatic logic [31:0] or_words(input logic [1919:0] ex, input int lo, input int hi);
    logic [31:0] r;
    r = '0;
    for (int k = lo; k <= hi; k++) r = r | ex[1919-32*k -: 32];
    return r;
  endfunction

  // Leaves the bench at the negedge inside cycle 1 (cyc = 1).
  task automatic run_start(input logic [255:0] k, input logic [1:0] m);
    @(negedge clk);
    key = k; mode = m; key_en = 1'b1;
    @(negedge clk);
    key_en = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(input int budget);
    ok0_cyc = 0; ok1_cyc = 0; sbox1_n = 0; busy0_at_ok = 1'b1;
    while (cyc <= budget && (ok0_cyc == 0 || ok1_cyc == 0)) begin
      if (ok0 && ok0_cyc == 0) begin ok0_cyc = cyc; busy0_at_ok = busy0; end
      if (ok1 && ok1_cyc == 0) ok1_cyc = cyc;
      if (use1 && ok1_cyc == 0) sbox1_n++;
      if (ok0_cyc == 0 || ok1_cyc == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // Start request in the same cycle as reset must be ignored.
    key = K128; mode = 2'd0; key_en = 1'b1;
    @(negedge clk);
    key_en = 1'b0; rst = 1'b0;
    check_eq("rst_busy",   busy0, 1'b0);
    check_eq("rst_ok",     ok0, 1'b0);
    check_eq("rst_err",    err0, 1'b0);
    check_eq("rst_nr",     nr0, 4'd0);
    check_eq("rst_use",    use0, 1'b0);
    check_eq("rst_din",    din0, 32'h0);
    check_eq("rst_exkey",  {31'b0, |exkey0}, 32'h0);
    check_eq("rst_busy1",  busy1, 1'b0);

    // AES-128
    run_start(K128, 2'd0);
    check_eq("a128_busy_c1", busy0, 1'b1);
    check_eq("a128_w0",      wd(exkey0, 0), 32'h00010203);
    check_eq("a128_w3",      wd(exkey0, 3), 32'h0c0d0e0f);
    check_eq("a128_w4z",     wd(exkey0, 4), 32'h0);
    check_eq("a128_use_c1",  use0, 1'b1);
    check_eq("a128_din_c1",  din0, 32'h0d0e0f0c);
    check_eq("a128_din1_c1", din1, 32'h0d0e0f0c);
    wait_done(120);
    check_eq("a128_ok_cyc0",  ok0_cyc, 41);
    check_eq("a128_ok_cyc1",  ok1_cyc, 51);
    check_eq("a128_busy_ok0", busy0_at_ok, 1'b0);
    check_eq("a128_busy_ok1", busy1, 1'b0);
    check_eq("a128_nr",       nr0, 4'd10);
    check_eq("a128_w4",       wd(exkey0, 4), 32'hd6aa74fd);
    check_eq("a128_w40",      wd(exkey0, 40), 32'h13111d7f);
    check_eq("a128_w41",      wd(exkey0, 41), 32'he3944a17);
    check_eq("a128_w42",      wd(exkey0, 42), 32'hf307a78b);
    check_eq("a128_w43",      wd(exkey0, 43), 32'h4d2b30c5);
    check_eq("a128_tail",     or_words(exkey0, 44, 59), 32'h0);
    check_eq("a128_w43_l1",   wd(exkey1, 43), 32'h4d2b30c5);
    check_eq("a128_nr_l1",    nr1, 4'd10);

    // Illegal mode after a complete schedule
    run_start(K128, 2'd3);
    check_eq("bad_err",   err0, 1'b1);
    check_eq("bad_ok",    ok0, 1'b0);
    check_eq("bad_nr",    nr0, 4'd0);
    check_eq("bad_busy",  busy0, 1'b0);
    check_eq("bad_exkey", {31'b0, |exkey0}, 32'h0);
    check_eq("bad_err1",  err1, 1'b1);

    // AES-192
    run_start(K192, 2'd1);
    check_eq("a192_err_clr", err0, 1'b0);
    check_eq("a192_w5",      wd(exkey0, 5), 32'h14151617);
    wait_done(120);
    check_eq("a192_ok_cyc0", ok0_cyc, 47);
    check_eq("a192_ok_cyc1", ok1_cyc, 55);
    check_eq("a192_nr",      nr0, 4'd12);
    check_eq("a192_w48",     wd(exkey0, 48), 32'ha4970a33);
    check_eq("a192_w49",     wd(exkey0, 49), 32'h1a78dc09);
    check_eq("a192_w50",     wd(exkey0, 50), 32'hc418c271);
    check_eq("a192_w51",     wd(exkey0, 51), 32'he3a41d5d);
    check_eq("a192_w51_l1",  wd(exkey1, 51), 32'he3a41d5d);
    check_eq("a192_tail",    or_words(exkey0, 52, 59), 32'h0);

    // AES-256
    run_start(K256, 2'd2);
    wait_done(120);
    check_eq("a256_ok_cyc0", ok0_cyc, 53);
    check_eq("a256_ok_cyc1", ok1_cyc, 66);
    check_eq("a256_sbox_n1", sbox1_n, 26);
    check_eq("a256_nr1",     nr1, 4'd14);
    check_eq("a256_w56_l1",  wd(exkey1, 56), 32'h24fc79cc);
    check_eq("a256_w57_l1",  wd(exkey1, 57), 32'hbf0979e9);
    check_eq("a256_w58_l1",  wd(exkey1, 58), 32'h371ac23c);
    check_eq("a256_w59_l1",  wd(exkey1, 59), 32'h6d68de36);
    check_eq("a256_w59",     wd(exkey0, 59), 32'h6d68de36);

    // AES-256 aborted by an AES-128 start at cycle 20
    run_start(K256, 2'd2);
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    key = K128; mode = 2'd0; key_en = 1'b1;
    @(negedge clk);
    key_en = 1'b0;
    cyc++;
    wait_done(150);
    check_eq("rs_ok_cyc0", ok0_cyc, 61);
    check_eq("rs_ok_cyc1", ok1_cyc, 71);
    check_eq("rs_nr",      nr0, 4'd10);
    check_eq("rs_w43",     wd(exkey0, 43), 32'h4d2b30c5);
    check_eq("rs_tail",    or_words(exkey0, 44, 59), 32'h0);
    check_eq("rs_tail1",   or_words(exkey1, 44, 59), 32'h0);

`ifdef AES_KEYEX_ZEROIZE_EN
    begin
      logic seen_ok;
      run_start(K192, 2'd1);
      while (cyc < 30) begin
        @(negedge clk);
        cyc++;
      end
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      check_eq("zz_busy",  busy0, 1'b0);
      check_eq("zz_exkey", {31'b0, |exkey0}, 32'h0);
      check_eq("zz_nr",    nr0, 4'd0);
      check_eq("zz_busy1", busy1, 1'b0);
      seen_ok = 1'b0;
      repeat (60) begin
        @(negedge clk);
        seen_ok = seen_ok | ok0 | ok1;
      end
      check_eq("zz_no_ok", seen_ok, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
